// File: rtl/shift_iter_unit_pkg.sv
// Shared constants and types for the iterative shift unit.
package shift_iter_unit_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned K_W     = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [K_W-1:0] K_FIRST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_stage_mux.sv
// Fixed-distance shift stages (16/8/4/2/1) and the per-cycle selector.
module shift_stage_mux
  import shift_iter_unit_pkg::*;
(
  input  logic [WIDTH-1:0] acc_i,
  input  logic [K_W-1:0]   k_i,
  input  logic [1:0]       op_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] sll, srl, sra;

  always_comb begin
    sll = acc_i;
    srl = acc_i;
    sra = acc_i;
    case (k_i)
      3'd4: begin
        sll = acc_i << 16;
        srl = acc_i >> 16;
        sra = $signed(acc_i) >>> 16;
      end
      3'd3: begin
        sll = acc_i << 8;
        srl = acc_i >> 8;
        sra = $signed(acc_i) >>> 8;
      end
      3'd2: begin
        sll = acc_i << 4;
        srl = acc_i >> 4;
        sra = $signed(acc_i) >>> 4;
      end
      3'd1: begin
        sll = acc_i << 2;
        srl = acc_i >> 2;
        sra = $signed(acc_i) >>> 2;
      end
      3'd0: begin
        sll = acc_i << 1;
        srl = acc_i >> 1;
        sra = $signed(acc_i) >>> 1;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_o = acc_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  acc_o = sll;
        OP_SRL:  acc_o = srl;
        OP_SRA:  acc_o = sra;
        default: acc_o = acc_i;  // reserved op passes through
      endcase
    end
  end

endmodule

// File: rtl/shift_iter_unit.sv
// Multi-cycle 32-bit shifter: one power-of-two distance per cycle, MSB first,
// always five SHIFT cycles, valid/ready on both sides.
module shift_iter_unit
  import shift_iter_unit_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [1:0]         op_q, op_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [WIDTH-1:0]   stage_out;

  shift_stage_mux u_stage_mux (
    .acc_i (acc_q),
    .k_i   (k_q),
    .op_i  (op_q),
    .en_i  (shamt_q[k_q]),
    .acc_o (stage_out)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    data_out_d = data_out_q;
    shamt_d    = shamt_q;
    op_d       = op_q;
    k_d        = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = data_in;
          shamt_d = shamt;
          op_d    = op;
          k_d     = K_FIRST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_out;
        if (k_q == '0) begin
          data_out_d = stage_out;
          state_d    = ST_DONE;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      data_out_q <= '0;
      shamt_q    <= '0;
      op_q       <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
      shamt_q    <= shamt_d;
      op_q       <= op_d;
      k_q        <= k_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed bench for shift_iter_unit with a result scoreboard queue.
module tb_shift_iter_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_in = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  shift_iter_unit dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [1:0] o);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $signed(d) >>> s;
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", 32'(in_ready), 32'd1);
  endtask

  // Called just after the acceptance edge; returns edges until out_valid.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s,
                         input logic [1:0] o, input logic [31:0] exp);
    int cyc;
    exp_q.push_back(exp);
    wait_idle();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = d;
    shamt     = s;
    op        = o;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd5);
    check({tag, "_data"}, data_out, exp_q.pop_front());
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] rd, ra;
    logic [4:0]  rs;
    logic [1:0]  ro;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    reset = 1'b1;
    tick();

    run_one("sll4", 32'h0000_000F, 5'd4, 2'b00, 32'h0000_00F0);
    check("sll4_in_ready_after", 32'(in_ready), 32'd1);
    run_one("sra_neg31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    run_one("sra_pos31", 32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000);
    run_one("srl31", 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001);
    run_one("srl20", 32'hF0F0_F0F0, 5'd20, 2'b01, 32'h0000_0F0F);
    run_one("sll0", 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
    run_one("rsv7", 32'hDEAD_BEEF, 5'd7, 2'b11, 32'hDEAD_BEEF);
    run_one("sra_mid", 32'hC000_1234, 5'd13, 2'b10, 32'hFFFE_0000);

    for (int i = 0; i < 4; i++) begin
      rd = $urandom();
      rs = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 2));
      run_one("rand", rd, rs, ro, model(rd, rs, ro));
    end

    // Backpressure: hold DONE for 3 cycles while a second request waits.
    ra = 32'h0000_0F0F;
    exp_q.push_back(ra);
    wait_idle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'hF0F0_F0F0;
    shamt     = 5'd20;
    op        = 2'b01;
    tick();
    in_valid = 1'b0;
    wait_done(cyc);
    check("bp_latency", 32'(cyc), 32'd5);
    check("bp_data", data_out, exp_q.pop_front());
    exp_q.push_back(32'hFF00_0000);
    in_valid = 1'b1;
    data_in  = 32'h0000_00FF;
    shamt    = 5'd24;
    op       = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", data_out, ra);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_idle", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_second_accept", 32'(busy), 32'd1);
    check("bp_data_held_in_shift", data_out, ra);
    wait_done(cyc);
    check("bp2_latency", 32'(cyc), 32'd5);
    check("bp2_data", data_out, exp_q.pop_front());
    tick();

    // Reset at the 3rd SHIFT edge discards the operation.
    wait_idle();
    in_valid = 1'b1;
    data_in  = 32'hAAAA_5555;
    shamt    = 5'd3;
    op       = 2'b00;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_one("post_rst_sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_iter_unit.md
Name: shift_iter_unit

Overview:
- Multi-cycle 32-bit shift unit for the processor ALU path.
- Consumes the fixed-distance shift stages (left-logical, right-logical and right-arithmetic by 16, 8, 4, 2 and 1) and applies one distance per cycle, selected by the shift-amount bits.
- Sits between the execute-stage operand latch and the ALU result mux.
- Uses a valid/ready handshake so the pipeline can stall on it instead of paying for a single-cycle 5-level barrel shifter.

Parameters:
- WIDTH, 32, data width; fixed, since the stage library is 32-bit only.
- SHAMT_W, 5, shift-amount width; log2(WIDTH).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- data_in  input  32  operand to shift.
- shamt  input  5  shift amount, 0..31.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes the result.
- data_out  output  32  shift result; registered.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, data_out=0, out_valid=0, busy=0, in_ready=1, internal shamt/op/stage registers=0. Reset overrides every other event, including an in-flight operation, which is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid=1 at the edge:
  - latch data_in into the accumulator, plus shamt and op;
  - stage index k=4;
  - go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT: in_ready=0, busy=1. Each edge:
  - if shamt[k]=1, accumulator <= stage(op, 2^k)(accumulator); otherwise accumulator is unchanged;
  - k decrements;
  - after the k=0 edge, go to DONE.
  - Exactly 5 SHIFT cycles, independent of the shamt value (no early exit).
- Stage function for distance d:
  - SLL: low d bits zero-filled.
  - SRL: high d bits zero-filled.
  - SRA: high d bits filled with accumulator[31], the current sign, which equals the original sign.
  - op=11: pass-through at every stage.
- DONE: out_valid=1, data_out=accumulator, busy=1.
  - out_ready=1 at the edge: go to IDLE, out_valid drops.
  - out_ready=0: data_out and out_valid hold indefinitely.
- Latency: acceptance edge E0; out_valid high after edge E5; earliest next acceptance at E7 (one IDLE cycle after E6).
- in_valid during SHIFT or DONE is ignored. The requester must hold its request until it sees in_ready=1.
- data_out holds its last value in IDLE and SHIFT; it updates only on entry to DONE.
- shamt=0 takes the same 5-cycle latency and returns the operand unchanged.
- No wrap-around: shift amounts beyond 31 are not representable.

Decomposition:
- Shared constants file:
  - OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSV=2'b11.
  - State encodings ST_IDLE, ST_SHIFT, ST_DONE.
  - WIDTH and SHAMT_W.
- One sub-module, shift_stage_mux. It instantiates the fixed sll/srl/sra stages for distances 16/8/4/2/1 and selects among them by k, op and the enable bit. It is purely combinational.
- The FSM, counter and registers live in shift_iter_unit.

Test Plan:
- SLL: data_in=0x0000000F, shamt=4, out_ready=1 -> data_out=0x000000F0; out_valid high exactly after the 5th edge following acceptance, for one cycle.
- SRA: data_in=0x80000000, shamt=31 -> 0xFFFFFFFF. Also data_in=0x7FFFFFFF, shamt=31 -> 0x00000000.
- SRL: data_in=0x80000000, shamt=31 -> 0x00000001. Also data_in=0xF0F0F0F0, shamt=20 -> 0x00000F0F.
- Boundary ops: shamt=0 with op=SLL and data_in=0x12345678 -> 0x12345678, with the same latency. op=11 with shamt=7 and data_in=0xDEADBEEF -> 0xDEADBEEF.
- Backpressure: out_ready=0 for 3 cycles in DONE, with a new in_valid=1 driven throughout -> out_valid and data_out stable, in_ready=0, second request not accepted until after the out_ready=1 edge plus the return to IDLE.
- Reset: reset=0 at the 3rd SHIFT edge -> next cycle state IDLE, out_valid=0, busy=0, in_ready=1, data_out=0. A following request, SLL 0x1 shamt=31, yields 0x80000000.
